// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared ghost-mode state encoding and phase-table defaults
//
// Contents:
//   ghostState_t       scheduler states IDLE / RUN / FRIGHT
//   PHASE_COUNT        number of scatter/chase phases (8)
//   CHASE_PHASE_LAST   index of the final, unbounded chase phase (7)
//   DEF_*              default durations in seconds and clk cycles per second
package pacman_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FRIGHT = 2'd2
  } ghostState_t;

  localparam int         PHASE_COUNT      = 8;
  localparam logic [2:0] CHASE_PHASE_LAST = 3'd7;

  localparam int DEF_SEC_DIV    = 25_000_000;
  localparam int DEF_SCAT0_SEC  = 7;
  localparam int DEF_CHASE0_SEC = 20;
  localparam int DEF_SCAT1_SEC  = 7;
  localparam int DEF_CHASE1_SEC = 20;
  localparam int DEF_SCAT2_SEC  = 5;
  localparam int DEF_CHASE2_SEC = 20;
  localparam int DEF_SCAT3_SEC  = 5;
  localparam int DEF_FRIGHT_SEC = 6;

endpackage

// File: rtl/ghost_mode_scheduler_sec_prescaler.sv
// rtl/ghost_mode_scheduler_sec_prescaler.sv - clk-to-seconds prescaler for the ghost mode scheduler
//
// Macro: FRIGHT_FLASH_EN adds the halfTick output.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             count this cycle
//   clr            restart the second (wins over en)
//   secTick        presc is at SEC_DIV-1 and enabled: a second elapses this cycle
//   halfTick       presc is at SEC_DIV/2-1 and enabled (FRIGHT_FLASH_EN only)
module sec_prescaler
  import pacman_pkg::*;
#(
  parameter int SEC_DIV = DEF_SEC_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic secTick
`ifdef FRIGHT_FLASH_EN
  ,
  output logic halfTick
`endif
);

  localparam int            PW   = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SEC_DIV - 1);

  logic [PW-1:0] presc;

  assign secTick = en && (presc == LAST);

`ifdef FRIGHT_FLASH_EN
  localparam logic [PW-1:0] HALF = PW'((SEC_DIV >= 2) ? (SEC_DIV / 2 - 1) : 0);
  assign halfTick = en && (SEC_DIV >= 2) && (presc == HALF);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= secTick ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - global scatter/chase/frightened sequencer for the ghost movers
//
// Macro: FRIGHT_FLASH_EN enables fright_flash; otherwise it is tied to 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          pulse: (re)start the phase table at phase 0
//   freeze         level: hold all timers and state, suppress reverse
//   power_pellet   pulse: enter or extend frightened
//   isChase        chase mode to ghosts (registered)
//   isScatter      scatter mode to ghosts (registered)
//   isFrightened   frightened mode (registered)
//   reverse        one-cycle direction-reversal strobe
//   phase          current phase index 0..7
//   fright_flash   end-of-fright warning blink
module ghost_mode_scheduler
  import pacman_pkg::*;
#(
  parameter int SEC_DIV    = DEF_SEC_DIV,
  parameter int SCAT0_SEC  = DEF_SCAT0_SEC,
  parameter int CHASE0_SEC = DEF_CHASE0_SEC,
  parameter int SCAT1_SEC  = DEF_SCAT1_SEC,
  parameter int CHASE1_SEC = DEF_CHASE1_SEC,
  parameter int SCAT2_SEC  = DEF_SCAT2_SEC,
  parameter int CHASE2_SEC = DEF_CHASE2_SEC,
  parameter int SCAT3_SEC  = DEF_SCAT3_SEC,
  parameter int FRIGHT_SEC = DEF_FRIGHT_SEC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       freeze,
  input  logic       power_pellet,
  output logic       isChase,
  output logic       isScatter,
  output logic       isFrightened,
  output logic       reverse,
  output logic [2:0] phase,
  output logic       fright_flash
);

  ghostState_t state, stateN;
  logic [2:0]  phaseN;
  logic [5:0]  secCnt, secCntN;
  logic [5:0]  frightCnt, frightCntN;
  logic [5:0]  curDur;
  logic        reverseN;
  logic        prescEn, prescClr;
  logic        secTick;
`ifdef FRIGHT_FLASH_EN
  logic        halfTick;
`endif

  // Timers only advance while a sequence is live and the game is not frozen.
  assign prescEn = (state != IDLE) && !freeze;

  sec_prescaler #(
    .SEC_DIV(SEC_DIV)
  ) uPresc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (prescEn),
    .clr     (prescClr),
    .secTick (secTick)
`ifdef FRIGHT_FLASH_EN
    ,
    .halfTick(halfTick)
`endif
  );

  always_comb begin
    curDur = 6'd63;
    case (phase)
      3'd0:    curDur = 6'(SCAT0_SEC);
      3'd1:    curDur = 6'(CHASE0_SEC);
      3'd2:    curDur = 6'(SCAT1_SEC);
      3'd3:    curDur = 6'(CHASE1_SEC);
      3'd4:    curDur = 6'(SCAT2_SEC);
      3'd5:    curDur = 6'(CHASE2_SEC);
      3'd6:    curDur = 6'(SCAT3_SEC);
      default: curDur = 6'd63;
    endcase
  end

  // Priority: start (even while frozen) > power_pellet > timer expiry.
  always_comb begin
    stateN     = state;
    phaseN     = phase;
    secCntN    = secCnt;
    frightCntN = frightCnt;
    reverseN   = 1'b0;
    prescClr   = 1'b0;
    if (start) begin
      stateN     = RUN;
      phaseN     = 3'd0;
      secCntN    = 6'd0;
      frightCntN = 6'd0;
      prescClr   = 1'b1;
    end else if (!freeze) begin
      case (state)
        RUN: begin
          if (power_pellet) begin
            // Phase and secCnt stay put: the phase timer pauses during fright.
            stateN     = FRIGHT;
            frightCntN = 6'd0;
            reverseN   = 1'b1;
            prescClr   = 1'b1;
          end else if (secTick) begin
            if (phase != CHASE_PHASE_LAST && secCnt == curDur - 6'd1) begin
              phaseN   = phase + 3'd1;
              secCntN  = 6'd0;
              reverseN = 1'b1;
            end else if (secCnt != 6'd63) begin
              secCntN = secCnt + 6'd1;
            end
          end
        end
        FRIGHT: begin
          if (power_pellet) begin
            frightCntN = 6'd0;
            prescClr   = 1'b1;
          end else if (secTick) begin
            if (frightCnt == 6'(FRIGHT_SEC - 1)) begin
              stateN     = RUN;
              frightCntN = 6'd0;
              prescClr   = 1'b1;
            end else begin
              frightCntN = frightCnt + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= 3'd0;
      secCnt       <= 6'd0;
      frightCnt    <= 6'd0;
      reverse      <= 1'b0;
      isChase      <= 1'b0;
      isScatter    <= 1'b0;
      isFrightened <= 1'b0;
    end else begin
      state        <= stateN;
      phase        <= phaseN;
      secCnt       <= secCntN;
      frightCnt    <= frightCntN;
      reverse      <= reverseN;
      isChase      <= (stateN == RUN) && phaseN[0];
      isScatter    <= (stateN == RUN) && !phaseN[0];
      isFrightened <= (stateN == FRIGHT);
    end
  end

`ifdef FRIGHT_FLASH_EN
  logic flashWin, flashWinN, flashN;

  assign flashWin  = (state == FRIGHT) && (int'(frightCnt) + 2 >= FRIGHT_SEC);
  assign flashWinN = (stateN == FRIGHT) && (int'(frightCntN) + 2 >= FRIGHT_SEC);

  // Lights on entering the last two seconds, then flips on every half second.
  always_comb begin
    flashN = 1'b0;
    if (flashWinN) begin
      flashN = flashWin ? (fright_flash ^ (halfTick | secTick)) : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fright_flash <= 1'b0;
    end else begin
      fright_flash <= flashN;
    end
  end
`else
  assign fright_flash = 1'b0;
`endif

endmodule
